// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - CPU load/store to APB master bridge with one-hot slave decode
//
// Latches one CPU load/store, decodes the address into a one-hot PSEL and
// runs the APB SETUP/ACCESS sequence. It completes with a one-cycle ready
// pulse. A decode miss, or a timeout when enabled, completes with ready and
// err together and rdata=0.
//
// Optional feature: define APB_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYC cycles in ACCESS without PREADY.
//
// Ports:
//   PCLK, PRESET           clock, asynchronous active-high reset
//   transfer, write        CPU request strobe (sampled in IDLE) and direction
//   addr, wdata            CPU byte address and store data
//   rdata, ready, err      load data, completion pulse, error qualifier
//   PADDR, PWDATA, PWRITE  registered APB address, write data and direction
//   PENABLE, PSEL          APB access phase and one-hot slave select
//   PRDATA, PREADY         per-slave read data (slave i at [32*i +: 32]) and ready
module apb_master_bridge #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [32*NUM_SLV-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;

  logic [19:0]      w_page;
  logic             w_hit;
  logic             w_latch;
  logic             w_done_ok;
  logic             w_done_err;
  logic             w_pready;
  logic [31:0]      w_prdata;
  logic             w_timeout;

  // Each slave owns a 4 KB page above BASE_ADDR.
  assign w_page = 20'((addr - BASE_ADDR) >> 12);
  assign w_hit  = (addr >= BASE_ADDR) && (w_page < 20'(NUM_SLV));

  // Only the selected slave's PREADY/PRDATA are looked at, so undriven or
  // unknown lanes of idle slaves cannot disturb the transfer.
  always_comb begin
    PSEL     = '0;
    w_pready = 1'b0;
    w_prdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        PSEL[i]  = (r_state != IDLE);
        w_pready = PREADY[i];
        w_prdata = PRDATA[32*i +: 32];
      end
    end
  end

  // PSEL/PENABLE decode straight from the state register so a reset drops
  // them without waiting for a clock edge.
  assign PENABLE = (r_state == ACCESS);

`ifdef APB_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wait_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !w_pready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Fires on the wait cycle that would bring the count to TIMEOUT_CYC.
  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout            = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (transfer) begin
          w_latch = 1'b1;
          if (w_hit) begin
            w_state_nxt = SETUP;
          end else begin
            w_done_err = 1'b1;
          end
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (w_pready) begin
          w_done_ok   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_done_err  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
      r_idx  <= '0;
      rdata  <= '0;
      ready  <= 1'b0;
      err    <= 1'b0;
    end else begin
      ready <= w_done_ok | w_done_err;
      err   <= w_done_err;
      if (w_latch) begin
        PADDR  <= addr;
        PWDATA <= wdata;
        PWRITE <= write;
        r_idx  <= w_page[IDX_W-1:0];
      end
      if (w_done_err) begin
        rdata <= '0;
      end else if (w_done_ok && !PWRITE) begin
        rdata <= w_prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          transfer = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic          err;
  logic [31:0]   PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PENABLE;
  logic [3:0]    PSEL;
  logic [127:0]  PRDATA = '0;
  logic [3:0]    PREADY = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .NUM_SLV     (4),
    .BASE_ADDR   (32'h1000_0000),
    .TIMEOUT_CYC (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Presents a request for one edge, then withdraws it.
  task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    tick();
    transfer = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge PCLK);
    chk("rst_psel",    32'(PSEL),    32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_ready",   32'(ready),   32'h0);
    chk("rst_err",     32'(err),     32'h0);
    chk("rst_paddr",   PADDR,        32'h0);
    chk("rst_rdata",   rdata,        32'h0);
    PRESET = 1'b0;
    tick();

    // Store to slave 0 with a registered-PREADY slave: ready after 4 edges
    start(1'b1, 32'h1000_0004, 32'd1234);
    chk("st_psel_setup",    32'(PSEL),    32'h1);
    chk("st_penable_setup", 32'(PENABLE), 32'h0);
    chk("st_paddr",         PADDR,        32'h1000_0004);
    chk("st_pwdata",        PWDATA,       32'd1234);
    chk("st_pwrite",        32'(PWRITE),  32'h1);
    tick();
    chk("st_penable_access", 32'(PENABLE), 32'h1);
    chk("st_ready_c2",       32'(ready),   32'h0);
    tick();
    chk("st_ready_c3", 32'(ready), 32'h0);
    PREADY[0] = 1'b1;
    tick();
    chk("st_ready_c4",   32'(ready),   32'h1);
    chk("st_err",        32'(err),     32'h0);
    chk("st_psel_done",  32'(PSEL),    32'h0);
    chk("st_penable_dn", 32'(PENABLE), 32'h0);
    PREADY = '0;

    // Load from slave 2, unselected lanes unknown
    PREADY         = 'x;
    PREADY[2]      = 1'b1;
    PRDATA         = 'x;
    PRDATA[64+:32] = 32'h0000_00A5;
    start(1'b0, 32'h1000_2008, 32'h0);
    chk("ld2_psel", 32'(PSEL), 32'h4);
    tick();
    chk("ld2_penable", 32'(PENABLE), 32'h1);
    tick();
    chk("ld2_ready", 32'(ready), 32'h1);
    chk("ld2_err",   32'(err),   32'h0);
    chk("ld2_rdata", rdata,      32'h0000_00A5);
    tick();
    chk("ld2_ready_pulse", 32'(ready), 32'h0);
    PREADY = '0;
    PRDATA = '0;

    // Store to slave 1 with five wait states; rdata must keep the last load
    start(1'b1, 32'h1000_1010, 32'hCAFE_F00D);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("ws_penable", 32'(PENABLE), 32'h1);
      chk("ws_paddr",   PADDR,        32'h1000_1010);
      chk("ws_ready",   32'(ready),   32'h0);
      tick();
    end
    PREADY[1] = 1'b1;
    chk("ws_ready_before", 32'(ready), 32'h0);
    tick();
    chk("ws_ready",       32'(ready), 32'h1);
    chk("ws_err",         32'(err),   32'h0);
    chk("ws_rdata_kept",  rdata,      32'h0000_00A5);
    tick();
    chk("ws_ready_pulse", 32'(ready), 32'h0);
    PREADY = '0;

    // Decode misses: far above, first address past the window, below base
    start(1'b0, 32'h2000_0000, 32'h0);
    chk("miss_ready", 32'(ready), 32'h1);
    chk("miss_err",   32'(err),   32'h1);
    chk("miss_rdata", rdata,      32'h0);
    chk("miss_psel",  32'(PSEL),  32'h0);
    tick();
    chk("miss_ready_pulse", 32'(ready), 32'h0);
    chk("miss_err_pulse",   32'(err),   32'h0);
    start(1'b0, 32'h1000_4000, 32'h0);
    chk("miss_top_err",  32'(err),  32'h1);
    chk("miss_top_psel", 32'(PSEL), 32'h0);
    tick();
    start(1'b1, 32'h0FFF_FFFC, 32'h0);
    chk("miss_low_err",  32'(err),  32'h1);
    chk("miss_low_psel", 32'(PSEL), 32'h0);
    tick();

    // Last word of slave 3, then a back-to-back request in the ready cycle
    PREADY[3]      = 1'b1;
    PRDATA[96+:32] = 32'h3C3C_0001;
    start(1'b0, 32'h1000_3FFC, 32'h0);
    chk("s3_psel", 32'(PSEL), 32'h8);
    tick();
    tick();
    chk("s3_ready", 32'(ready), 32'h1);
    chk("s3_rdata", rdata,      32'h3C3C_0001);
    PRDATA[96+:32] = 32'h0000_0777;
    start(1'b0, 32'h1000_3000, 32'h0);
    chk("b2b_psel",    32'(PSEL),    32'h8);
    chk("b2b_penable", 32'(PENABLE), 32'h0);
    tick();
    tick();
    chk("b2b_ready", 32'(ready), 32'h1);
    chk("b2b_rdata", rdata,      32'h0000_0777);
    PREADY = '0;
    PRDATA = '0;
    tick();

    // Reset in the middle of ACCESS
    start(1'b1, 32'h1000_1000, 32'h55);
    tick();
    chk("rma_penable_pre", 32'(PENABLE), 32'h1);
    #2 PRESET = 1'b1;
    #1;
    chk("rma_psel",    32'(PSEL),    32'h0);
    chk("rma_penable", 32'(PENABLE), 32'h0);
    chk("rma_paddr",   PADDR,        32'h0);
    @(negedge PCLK);
    PRESET    = 1'b0;
    PREADY[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rma_no_ready", 32'(ready), 32'h0);
    end
    PREADY = '0;

    // Normal load after the reset
    PREADY[0]     = 1'b1;
    PRDATA[0+:32] = 32'hDEAD_BEEF;
    start(1'b0, 32'h1000_000C, 32'h0);
    chk("post_psel", 32'(PSEL), 32'h1);
    tick();
    chk("post_ready_c2", 32'(ready), 32'h0);
    tick();
    chk("post_ready", 32'(ready), 32'h1);
    chk("post_err",   32'(err),   32'h0);
    chk("post_rdata", rdata,      32'hDEAD_BEEF);
    PREADY = '0;
    PRDATA = '0;
    tick();

`ifdef APB_TIMEOUT_EN
    // Stuck slave: abort after 16 ACCESS cycles
    start(1'b1, 32'h1000_1000, 32'h1);
    tick();
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("to_wait_ready", 32'(ready), 32'h0);
    end
    tick();
    chk("to_ready",   32'(ready),   32'h1);
    chk("to_err",     32'(err),     32'h1);
    chk("to_rdata",   rdata,        32'h0);
    chk("to_penable", 32'(PENABLE), 32'h0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
